// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, LSB-first data and a configurable stop length.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx #(
  parameter int N_BITS   = 8,
  parameter int SB_TICKS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  input  logic              tick,
  output logic [N_BITS-1:0] dout,
  output logic              rx_done,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int NW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [NW-1:0] LAST_BIT  = NW'(N_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(SB_TICKS - 1);
  localparam logic [3:0]    MID_START = 4'd7;
  localparam logic [3:0]    BIT_LAST  = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic              rxMeta_q;
  logic              rxS_q;
  state_t            state_q;
  logic [3:0]        s_q;
  logic [NW-1:0]     n_q;
  logic [N_BITS-1:0] shift_q;
  logic [N_BITS-1:0] shift_d;
  logic [N_BITS-1:0] dout_q;
  logic              rxDone_q;
  logic              frameErr_q;

  // The line idles high, so the synchronizer comes out of reset at 1 to avoid a false start.
  always_ff @(posedge clock) begin
    if (reset) begin
      rxMeta_q <= 1'b1;
      rxS_q    <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxS_q    <= rxMeta_q;
    end
  end

  assign shift_d = {rxS_q, shift_q[N_BITS-1:1]};

`ifdef UART_RX_PARITY_EN
  logic parityBit_q;
  logic parityErr_q;
  logic parityErr_d;

  assign parityErr_d = (^shift_q) ^ parityBit_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      s_q        <= '0;
      n_q        <= '0;
      shift_q    <= '0;
      dout_q     <= '0;
      rxDone_q   <= 1'b0;
      frameErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBit_q <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      rxDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rxS_q) begin
            state_q <= START;
            s_q     <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s_q == MID_START) begin
              if (!rxS_q) begin
                state_q <= DATA;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_q <= s_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_q == BIT_LAST) begin
              s_q     <= '0;
              shift_q <= shift_d;
              if (n_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (s_q == BIT_LAST) begin
              s_q         <= '0;
              parityBit_q <= rxS_q;
              state_q     <= STOP;
            end else begin
              s_q <= s_q + 4'd1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (s_q == STOP_LAST) begin
              state_q    <= IDLE;
              rxDone_q   <= 1'b1;
              dout_q     <= shift_q;
              frameErr_q <= ~rxS_q;
`ifdef UART_RX_PARITY_EN
              parityErr_q <= parityErr_d;
`endif
            end else begin
              s_q <= s_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout      = dout_q;
  assign rx_done   = rxDone_q;
  assign frame_err = frameErr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parityErr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: frames are serialised at 16x4 clocks per bit and
// every rx_done pulse is captured and matched against the queued expectation.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int NPAY = 9;
`else
  localparam int NPAY = 8;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } rec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic       tick;
  logic [7:0] dout;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;

  rec_t gotQ[$];
  rec_t expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   tickCnt     = 0;

  uart_rx #(.N_BITS(8), .SB_TICKS(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .tick       (tick),
    .dout       (dout),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clock = ~clock;

  // Baud generator stand-in: one tick every fourth clock.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clock);
      tickCnt = (tickCnt + 1) % 4;
      tick = (tickCnt == 0);
    end
  end

  // Every clock with rx_done high is logged, so a stretched pulse shows up as extra entries.
  always @(negedge clock) begin
    if (rx_done === 1'b1) gotQ.push_back(rec_t'({dout, frame_err, parity_err}));
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idleClocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // A low stop bit is held past its mid-point only, so the receiver sees a clean return to idle.
  task automatic sendFrame(input logic [7:0] d, input logic stopLow, input logic parBit);
    logic [8:0] payload;
    payload = {parBit, d};
    rx = 1'b0;
    idleClocks(BIT_CLKS);
    for (int i = 0; i < NPAY; i++) begin
      rx = payload[i];
      idleClocks(BIT_CLKS);
    end
    if (stopLow) begin
      rx = 1'b0;
      idleClocks(BIT_CLKS / 2 + 16);
      rx = 1'b1;
      idleClocks(BIT_CLKS / 2 - 16);
    end else begin
      rx = 1'b1;
      idleClocks(BIT_CLKS);
    end
  endtask

  task automatic waitDone(input int n, input int budget);
    for (int i = 0; i < budget && gotQ.size() < n; i++) @(negedge clock);
    idleClocks(16);
  endtask

  task automatic test_reset();
    rx = 1'b1;
    reset = 1'b1;
    idleClocks(5);
    vectors++;
    if (dout !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_dout: got %h, expected 00", dout);
    end
    vectors++;
    if (rx_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_rx_done: got %b, expected 0", rx_done);
    end
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_frame_err: got %b, expected 0", frame_err);
    end
    vectors++;
    if (parity_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_parity_err: got %b, expected 0", parity_err);
    end
    reset = 1'b0;
    idleClocks(200);
    vectors++;
    if (gotQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle_quiet: got %0d rx_done pulses, expected 0", gotQ.size());
    end
    gotQ.delete();
  endtask

  task automatic test_single();
    rec_t got, exp;
    expQ.push_back('{data: 8'h55, fe: 1'b0, pe: 1'b0});
    sendFrame(8'h55, 1'b0, ^8'h55);
    waitDone(1, 2000);
    idleClocks(100);
    vectors++;
    if (gotQ.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL single_count: got %0d pulses, expected 1", gotQ.size());
    end
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      got = gotQ.pop_front();
      exp = expQ.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL single_frame: got dout=%h fe=%b pe=%b, expected dout=%h fe=%b pe=%b",
                 got.data, got.fe, got.pe, exp.data, exp.fe, exp.pe);
      end
    end
    vectors++;
    if (dout !== 8'h55 || frame_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_hold: got dout=%h fe=%b, expected dout=55 fe=0", dout, frame_err);
    end
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic test_back_to_back();
    rec_t got, exp;
    expQ.push_back('{data: 8'hA3, fe: 1'b0, pe: 1'b0});
    expQ.push_back('{data: 8'h0F, fe: 1'b0, pe: 1'b0});
    sendFrame(8'hA3, 1'b0, ^8'hA3);
    sendFrame(8'h0F, 1'b0, ^8'h0F);
    waitDone(2, 2000);
    vectors++;
    if (gotQ.size() != 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d pulses, expected 2", gotQ.size());
    end
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      got = gotQ.pop_front();
      exp = expQ.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL b2b_frame: got dout=%h fe=%b pe=%b, expected dout=%h fe=%b pe=%b",
                 got.data, got.fe, got.pe, exp.data, exp.fe, exp.pe);
      end
    end
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic test_start_glitch();
    rec_t got, exp;
    rx = 1'b0;
    idleClocks(20);
    rx = 1'b1;
    idleClocks(3 * BIT_CLKS);
    vectors++;
    if (gotQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL glitch_quiet: got %0d pulses, expected 0", gotQ.size());
    end
    gotQ.delete();
    expQ.push_back('{data: 8'h81, fe: 1'b0, pe: 1'b0});
    sendFrame(8'h81, 1'b0, ^8'h81);
    waitDone(1, 2000);
    vectors++;
    if (gotQ.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL glitch_next_count: got %0d pulses, expected 1", gotQ.size());
    end
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      got = gotQ.pop_front();
      exp = expQ.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL glitch_next_frame: got dout=%h fe=%b pe=%b, expected dout=%h fe=%b pe=%b",
                 got.data, got.fe, got.pe, exp.data, exp.fe, exp.pe);
      end
    end
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic test_frame_error();
    rec_t got, exp;
    expQ.push_back('{data: 8'h3C, fe: 1'b1, pe: 1'b0});
    expQ.push_back('{data: 8'h5A, fe: 1'b0, pe: 1'b0});
    sendFrame(8'h3C, 1'b1, ^8'h3C);
    rx = 1'b1;
    idleClocks(3 * BIT_CLKS);
    sendFrame(8'h5A, 1'b0, ^8'h5A);
    waitDone(2, 2000);
    vectors++;
    if (gotQ.size() != 2) begin
      miscompares++;
      $display("[TB] FAIL ferr_count: got %0d pulses, expected 2", gotQ.size());
    end
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      got = gotQ.pop_front();
      exp = expQ.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL ferr_frame: got dout=%h fe=%b pe=%b, expected dout=%h fe=%b pe=%b",
                 got.data, got.fe, got.pe, exp.data, exp.fe, exp.pe);
      end
    end
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic test_stuck_low();
    rec_t got, exp;
    int   seen;
    expQ.push_back('{data: 8'h00, fe: 1'b1, pe: 1'b0});
    expQ.push_back('{data: 8'h00, fe: 1'b1, pe: 1'b0});
    rx = 1'b0;
    idleClocks(1300);
    rx = 1'b1;
    idleClocks(12 * BIT_CLKS);
    seen = gotQ.size();
    vectors++;
    if (seen < 2) begin
      miscompares++;
      $display("[TB] FAIL stuck_count: got %0d pulses, expected at least 2", seen);
    end
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      got = gotQ.pop_front();
      exp = expQ.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL stuck_frame: got dout=%h fe=%b pe=%b, expected dout=%h fe=%b pe=%b",
                 got.data, got.fe, got.pe, exp.data, exp.fe, exp.pe);
      end
    end
    gotQ.delete();
    expQ.delete();
    expQ.push_back('{data: 8'h66, fe: 1'b0, pe: 1'b0});
    sendFrame(8'h66, 1'b0, ^8'h66);
    waitDone(1, 2000);
    vectors++;
    if (gotQ.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL stuck_recover_count: got %0d pulses, expected 1", gotQ.size());
    end
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      got = gotQ.pop_front();
      exp = expQ.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL stuck_recover_frame: got dout=%h fe=%b pe=%b, expected dout=%h fe=%b pe=%b",
                 got.data, got.fe, got.pe, exp.data, exp.fe, exp.pe);
      end
    end
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic test_reset_mid_frame();
    rec_t got, exp;
    rx = 1'b0;
    idleClocks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      idleClocks(BIT_CLKS);
    end
    idleClocks(BIT_CLKS / 2);
    reset = 1'b1;
    idleClocks(2);
    vectors++;
    if (dout !== 8'h00 || rx_done !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got dout=%h done=%b fe=%b pe=%b, expected all 0",
               dout, rx_done, frame_err, parity_err);
    end
    idleClocks(2);
    reset = 1'b0;
    idleClocks(12 * BIT_CLKS);
    vectors++;
    if (gotQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_quiet: got %0d pulses, expected 0", gotQ.size());
    end
    vectors++;
    if (dout !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL midreset_dout_hold: got %h, expected 00", dout);
    end
    gotQ.delete();
    expQ.push_back('{data: 8'h12, fe: 1'b0, pe: 1'b0});
    sendFrame(8'h12, 1'b0, ^8'h12);
    waitDone(1, 2000);
    vectors++;
    if (gotQ.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL midreset_next_count: got %0d pulses, expected 1", gotQ.size());
    end
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      got = gotQ.pop_front();
      exp = expQ.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL midreset_next_frame: got dout=%h fe=%b pe=%b, expected dout=%h fe=%b pe=%b",
                 got.data, got.fe, got.pe, exp.data, exp.fe, exp.pe);
      end
    end
    gotQ.delete();
    expQ.delete();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    rec_t got, exp;
    expQ.push_back('{data: 8'h07, fe: 1'b0, pe: 1'b0});
    expQ.push_back('{data: 8'h07, fe: 1'b0, pe: 1'b1});
    sendFrame(8'h07, 1'b0, 1'b1);
    sendFrame(8'h07, 1'b0, 1'b0);
    waitDone(2, 2000);
    vectors++;
    if (gotQ.size() != 2) begin
      miscompares++;
      $display("[TB] FAIL parity_count: got %0d pulses, expected 2", gotQ.size());
    end
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      got = gotQ.pop_front();
      exp = expQ.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL parity_frame: got dout=%h fe=%b pe=%b, expected dout=%h fe=%b pe=%b",
                 got.data, got.fe, got.pe, exp.data, exp.fe, exp.pe);
      end
    end
    gotQ.delete();
    expQ.delete();
  endtask
`endif

  initial begin
    rx = 1'b1;
    reset = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_start_glitch();
    test_frame_error();
    test_stuck_low();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
